// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: nibble width,
// FSM state encoding and the nibble-index width helper.
package nibble_serial_subtractor_pkg;

    // Width of one datapath slice
    localparam int NIBBLE = 4;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the nibble index: clog2(nib), never less than one bit
    function automatic int idx_width(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_cla.sv
// Four-bit carry-lookahead slice. Produces the nibble sum plus group
// generate/propagate; the parent forms the carry into the next nibble.
module carry_lookahead_4bit
    import nibble_serial_subtractor_pkg::*;
(
    input  logic [NIBBLE-1:0] A,
    input  logic [NIBBLE-1:0] B,
    input  logic              cin,
    output logic [NIBBLE-1:0] S,
    output logic              Gg,
    output logic              Pg
);

    logic [NIBBLE-1:0] g;
    logic [NIBBLE-1:0] p;
    logic [NIBBLE-1:0] c;

    // Bit generate/propagate, flattened lookahead carries, sum and group terms
    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        S    = p ^ c;
        Gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        Pg   = &p;
    end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle W-bit subtractor: a - b computed as a + ~b + 1, one nibble
// per clock, LSB nibble first, through a single carry-lookahead slice.
// Handshake: start is accepted on a rising edge while the block is not
// busy (IDLE or DONE); busy is high for the NIB processing cycles; done
// pulses for one cycle, and diff/borrow_out/overflow are valid from that
// cycle and hold until the next done.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int W = 16    // multiple of 4, at least 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out,
    output logic         overflow
);

    localparam int NIB = W / NIBBLE;
    localparam int KW  = idx_width(NIB);
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;     // holds ~b
    logic [W-1:0]   res_q, res_d;
    logic           carry_q, carry_d;
    logic [KW-1:0]  k_q, k_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   diff_q, diff_d;
    logic           borrow_q, borrow_d;
    logic           overflow_q, overflow_d;

    logic [NIBBLE-1:0] nib_a;
    logic [NIBBLE-1:0] nib_b;
    logic [NIBBLE-1:0] nib_s;
    logic              grp_g;
    logic              grp_p;
    logic              carry_next;
    logic [W-1:0]      res_next;

    // Select the current nibble of each operand for the slice
    always_comb begin
        nib_a = op_a_q[k_q * NIBBLE +: NIBBLE];
        nib_b = op_b_q[k_q * NIBBLE +: NIBBLE];
    end

    carry_lookahead_4bit u_slice (
        .A   (nib_a),
        .B   (nib_b),
        .cin (carry_q),
        .S   (nib_s),
        .Gg  (grp_g),
        .Pg  (grp_p)
    );

    // Inter-nibble carry and result register with the new nibble merged in
    always_comb begin
        carry_next = grp_g | (grp_p & carry_q);
        res_next   = res_q;
        res_next[k_q * NIBBLE +: NIBBLE] = nib_s;
    end

    // Controller next state: capture, nibble stepping, result load
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_d      = res_q;
        carry_d    = carry_q;
        k_d        = k_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_RUN: begin
                res_d   = res_next;
                carry_d = carry_next;
                if (k_q == K_LAST) begin
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    k_d        = '0;
                    diff_d     = res_next;
                    borrow_d   = ~carry_next;
                    // op_b holds ~b, so b's sign bit is ~op_b[W-1]
                    overflow_d = (op_a_q[W-1] == op_b_q[W-1])
                               & (res_next[W-1] != op_a_q[W-1]);
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: begin   // ST_IDLE, ST_DONE: ready to accept
                if (start) begin
                    state_d = ST_RUN;
                    op_a_d  = a;
                    op_b_d  = ~b;
                    res_d   = '0;
                    carry_d = 1'b1;
                    k_d     = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = overflow_q;

endmodule
